i2c_burst_datapath: RTL and testbench
=====================================

# i2c_burst_datapath

Parametrised successor to the single-byte I2C master datapath. It owns its own SCL phase counter, bit counter and command FSM, so it can be driven by a simple command handshake instead of per-state counter strobes. It generates START, repeated START, DATA_W-bit WRITE and READ frames with ACK, and STOP on open-drain-style `sda_o`/`scl_o`. It sits between the I2C controller's command sequencer and the pad logic.

## Interface
- `DATA_W`, 8: bits per data frame (1..32).
- `PRESC_W`, 8: width of `prescaler_i`.
- `MSB_FIRST`, 1: 1 = bit DATA_W-1 is sent and received first; 0 = bit 0 is first.

Ports:
- `i2c_core_clock_i`  in  1  core clock.
- `reset_bit_n_i`  in  1  asynchronous active-low reset.
- `prescaler_i`  in  PRESC_W  SCL half-period minus 1, in core clocks. Values below 2 are treated as 2.
- `cmd_valid_i`  in  1  command offered.
- `cmd_op_i`  in  3  command code: 0 START, 1 WRITE, 2 READ, 3 STOP, 4 RSTART. Codes 5–7 are illegal.
- `cmd_data_i`  in  DATA_W  WRITE payload.
- `cmd_ack_i`  in  1  ACK bit to drive after a READ (0 = ACK).
- `cmd_ready_o`  out  1  engine can accept a command.
- `sda_i`, `scl_i`  in  1  bus line samples.
- `sda_o`, `scl_o`  out  1  bus drive (1 = released).
- `rd_data_o`  out  DATA_W  last READ data.
- `ack_rx_o`  out  1  ACK sampled after the last WRITE.
- `done_o`  out  1  one-cycle command-complete pulse.
- `err_o`  out  1  one-cycle illegal-command pulse.
- `busy_o`  out  1  bus owned (START issued, no STOP yet).

## Operation
- FSM states:
  - IDLE: bus free, `scl_o`=1, `sda_o`=1.
  - START
  - BIT_LO, BIT_HI
  - ACK_LO, ACK_HI
  - STOP_LO, STOP_HI, STOP_END
  - RS_LO, RS_HI
  - HOLD: bus owned, `scl_o`=0, `sda_o` unchanged.
- `cmd_ready_o`=1 only in IDLE and HOLD. A command is accepted on `cmd_valid_i && cmd_ready_o`. `cmd_data_i` and `cmd_ack_i` are captured at acceptance.
- START in IDLE: `sda_o`→0, one half-period with `scl_o`=1, then HOLD.
- START in HOLD: executed as RSTART.
- WRITE, READ, STOP or RSTART in IDLE, or any illegal code: ignored. `err_o` pulses and the engine stays in IDLE.
- WRITE: DATA_W bits through BIT_LO/BIT_HI, then ACK with `sda_o`=1. The `sda_i` sample goes to `ack_rx_o`.
- READ: DATA_W bits with `sda_o`=1, shifting `sda_i` in. Then ACK driving the captured `cmd_ack_i`. `rd_data_o` updates at completion.
- STOP:
  - STOP_LO: `scl_o`=0, `sda_o`→0.
  - STOP_HI: `scl_o`=1.
  - STOP_END: `sda_o`→1 and hold one half-period.
  - Then IDLE, `busy_o`=0.
- RSTART:
  - RS_LO: `sda_o`→1.
  - RS_HI: `scl_o`=1.
  - Then `sda_o`→0 and hold one half-period with SCL high.
  - Then HOLD.
- The bit counter has width $clog2(DATA_W+1) and counts 0..DATA_W-1 for data, then the ACK slot.

## Timing
- Half-period counter `cnt` runs 0..P, where P = max(`prescaler_i`, 2). It wraps at P and advances the phase.
- A half-period is P+1 core clocks, so a WRITE or READ lasts (DATA_W+1)·2·(P+1) clocks.
- In *_LO phases, `sda_o` changes at `cnt`==1, one clock after the SCL falling edge.
- In *_HI phases, `sda_i` is sampled at `cnt`==P, the last high clock.
- `done_o` pulses in the cycle the FSM enters HOLD or IDLE at command end. `cmd_ready_o` rises in that same cycle.
- A command can be accepted in the same cycle `done_o` pulses. Back-to-back frames then have no idle SCL gap.
- `prescaler_i` is sampled only at `cnt`==0. A change in mid-half-period takes effect from the next half-period.
- Reset values: `scl_o`=1, `sda_o`=1, `cmd_ready_o`=1, `done_o`=0, `err_o`=0, `busy_o`=0, `rd_data_o`=0, `ack_rx_o`=1.
- Reset asserted mid-frame releases both lines immediately (asynchronous). No STOP is generated.

## Configuration
- `I2C_DP_CLK_STRETCH_EN` defined:
  - In *_HI phases, `cnt` holds at 0 while `scl_i`=0, so slave stretching extends the high phase.
  - Sampling occurs at `cnt`==P after SCL is actually seen high.
- Not defined: `scl_i` is ignored and the high-phase length is fixed.

## Test plan
- P=4, DATA_W=8, MSB_FIRST=1: START, then WRITE 0xA5 with slave ACK 0.
  - `sda_o` bit sequence 1,0,1,0,0,1,0,1, then released. `ack_rx_o`=0.
  - `done_o` occurs 90 clocks after acceptance.
- READ with the bus driving 0x3C and `cmd_ack_i`=1:
  - `rd_data_o`=0x3C.
  - `sda_o`=1 in the ACK slot. `done_o` pulses once.
- WRITE, then RSTART, then STOP:
  - SDA rises while SCL is low, then falls while SCL is high.
  - After STOP, `busy_o`=0, lines are 1/1 and the FSM is in IDLE.
- WRITE issued in IDLE, and `cmd_op_i`=6 in HOLD:
  - `err_o` pulses once for each.
  - No line activity. `cmd_ready_o` stays 1.
- Reset pulse in the middle of bit 3 of a WRITE:
  - `scl_o`/`sda_o`=1 in the same cycle and all outputs at reset values.
  - A subsequent START works normally.
- Stretch macro defined, `scl_i` held low for 20 clocks in BIT_HI: the frame lengthens by exactly 20 clocks. With the macro undefined, the frame length is unchanged.

Source files
------------

// File: rtl/i2c_burst_datapath.sv
// I2C master burst datapath: START/RSTART/STOP and DATA_W-bit WRITE/READ frames with ACK,
// driven by a command handshake. Optional SCL clock stretching: define I2C_DP_CLK_STRETCH_EN.
module i2c_burst_datapath #(
    parameter int DATA_W    = 8,
    parameter int PRESC_W   = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic               i2c_core_clock_i,
    input  logic               reset_bit_n_i,
    input  logic [PRESC_W-1:0] prescaler_i,
    input  logic               cmd_valid_i,
    input  logic [2:0]         cmd_op_i,
    input  logic [DATA_W-1:0]  cmd_data_i,
    input  logic               cmd_ack_i,
    output logic               cmd_ready_o,
    input  logic               sda_i,
    input  logic               scl_i,
    output logic               sda_o,
    output logic               scl_o,
    output logic [DATA_W-1:0]  rd_data_o,
    output logic               ack_rx_o,
    output logic               done_o,
    output logic               err_o,
    output logic               busy_o
);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] OP_START  = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_STOP   = 3'd3;
    localparam logic [2:0] OP_RSTART = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_BIT_LO, ST_BIT_HI, ST_ACK_LO, ST_ACK_HI,
        ST_STOP_LO, ST_STOP_HI, ST_STOP_END, ST_RS_LO, ST_RS_HI, ST_HOLD
    } state_t;

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] cnt_r, cnt_s, p_r, p_s, presc_clamp_s;
    logic [BIT_W-1:0]   bit_r, bit_s;
    logic [DATA_W-1:0]  shift_r, shift_s, rd_data_r, rd_data_s;
    logic               is_rd_r, is_rd_s, ack_r, ack_s;
    logic               scl_r, scl_s, sda_r, sda_s;
    logic               ready_r, ready_s, done_r, done_s, err_r, err_s, busy_r, busy_s;
    logic               ack_rx_r, ack_rx_s;
    logic               hi_phase_s, stall_s, wrap_s, in_hold_s, tx_bit_s;

    // Shift one received bit into the frame register in transmission order.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        logic [DATA_W-1:0] r;
        if (MSB_FIRST != 0) begin
            r    = v << 1;
            r[0] = b;
        end else begin
            r           = v >> 1;
            r[DATA_W-1] = b;
        end
        return r;
    endfunction

    assign presc_clamp_s = (prescaler_i < PRESC_W'(2)) ? PRESC_W'(2) : prescaler_i;
    assign hi_phase_s    = (state_r == ST_BIT_HI) || (state_r == ST_ACK_HI) ||
                           (state_r == ST_STOP_HI) || (state_r == ST_RS_HI);
    assign in_hold_s     = (state_r == ST_HOLD);
    assign tx_bit_s      = (MSB_FIRST != 0) ? shift_r[DATA_W-1] : shift_r[0];

`ifdef I2C_DP_CLK_STRETCH_EN
    // A slave holding SCL low keeps the high phase counter parked at zero.
    assign stall_s = hi_phase_s && (cnt_r == PRESC_W'(0)) && !scl_i;
`else
    logic scl_unused_s;
    assign scl_unused_s = scl_i;
    assign stall_s      = 1'b0;
`endif

    // Next-state, counters and bus drive for the command engine.
    always_comb begin
        state_s   = state_r;
        p_s       = (cnt_r == PRESC_W'(0)) ? presc_clamp_s : p_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        is_rd_s   = is_rd_r;
        ack_s     = ack_r;
        scl_s     = scl_r;
        sda_s     = sda_r;
        done_s    = 1'b0;
        err_s     = 1'b0;
        busy_s    = busy_r;
        rd_data_s = rd_data_r;
        ack_rx_s  = ack_rx_r;
        if (stall_s) begin
            wrap_s = 1'b0;
            cnt_s  = cnt_r;
        end else if (cnt_r == p_s) begin
            wrap_s = 1'b1;
            cnt_s  = PRESC_W'(0);
        end else begin
            wrap_s = 1'b0;
            cnt_s  = cnt_r + PRESC_W'(1);
        end

        case (state_r)
            ST_IDLE, ST_HOLD: begin
                cnt_s = PRESC_W'(0);
                if (cmd_valid_i && ready_r) begin
                    case (cmd_op_i)
                        OP_START: begin
                            if (in_hold_s) begin
                                state_s = ST_RS_LO;
                            end else begin
                                state_s = ST_START;
                                sda_s   = 1'b0;
                                busy_s  = 1'b1;
                            end
                        end
                        OP_WRITE, OP_READ: begin
                            if (in_hold_s) begin
                                state_s = ST_BIT_LO;
                                shift_s = cmd_data_i;
                                is_rd_s = (cmd_op_i == OP_READ);
                                ack_s   = cmd_ack_i;
                                bit_s   = BIT_W'(0);
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        OP_STOP: begin
                            if (in_hold_s) state_s = ST_STOP_LO;
                            else           err_s   = 1'b1;
                        end
                        OP_RSTART: begin
                            if (in_hold_s) state_s = ST_RS_LO;
                            else           err_s   = 1'b1;
                        end
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            ST_START: begin
                if (wrap_s) begin
                    state_s = ST_HOLD;
                    scl_s   = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_BIT_LO: begin
                if (cnt_r == PRESC_W'(0)) sda_s = is_rd_r ? 1'b1 : tx_bit_s;
                else                      sda_s = sda_r;
                if (wrap_s) begin
                    state_s = ST_BIT_HI;
                    scl_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_BIT_HI: begin
                if (wrap_s) begin
                    shift_s = shift_in(shift_r, sda_i);
                    bit_s   = bit_r + BIT_W'(1);
                    scl_s   = 1'b0;
                    state_s = (bit_r == BIT_W'(DATA_W - 1)) ? ST_ACK_LO : ST_BIT_LO;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ACK_LO: begin
                if (cnt_r == PRESC_W'(0)) sda_s = is_rd_r ? ack_r : 1'b1;
                else                      sda_s = sda_r;
                if (wrap_s) begin
                    state_s = ST_ACK_HI;
                    scl_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ACK_HI: begin
                if (wrap_s) begin
                    if (is_rd_r) rd_data_s = shift_r;
                    else         ack_rx_s  = sda_i;
                    state_s = ST_HOLD;
                    scl_s   = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_STOP_LO: begin
                if (cnt_r == PRESC_W'(0)) sda_s = 1'b0;
                else                      sda_s = sda_r;
                if (wrap_s) begin
                    state_s = ST_STOP_HI;
                    scl_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_STOP_HI: begin
                if (wrap_s) begin
                    state_s = ST_STOP_END;
                    sda_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_STOP_END: begin
                if (wrap_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RS_LO: begin
                if (cnt_r == PRESC_W'(0)) sda_s = 1'b1;
                else                      sda_s = sda_r;
                if (wrap_s) begin
                    state_s = ST_RS_HI;
                    scl_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            // The SDA fall with SCL high completes in ST_START, which then returns to HOLD.
            ST_RS_HI: begin
                if (wrap_s) begin
                    state_s = ST_START;
                    sda_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                scl_s   = 1'b1;
                sda_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE) || (state_s == ST_HOLD);
    end

    // State, datapath and registered output update.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_n_i) begin
        if (!reset_bit_n_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= PRESC_W'(0);
            p_r       <= PRESC_W'(2);
            bit_r     <= BIT_W'(0);
            shift_r   <= DATA_W'(0);
            is_rd_r   <= 1'b0;
            ack_r     <= 1'b1;
            scl_r     <= 1'b1;
            sda_r     <= 1'b1;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            rd_data_r <= DATA_W'(0);
            ack_rx_r  <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            p_r       <= p_s;
            bit_r     <= bit_s;
            shift_r   <= shift_s;
            is_rd_r   <= is_rd_s;
            ack_r     <= ack_s;
            scl_r     <= scl_s;
            sda_r     <= sda_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
            err_r     <= err_s;
            busy_r    <= busy_s;
            rd_data_r <= rd_data_s;
            ack_rx_r  <= ack_rx_s;
        end
    end

    assign cmd_ready_o = ready_r;
    assign scl_o       = scl_r;
    assign sda_o       = sda_r;
    assign rd_data_o   = rd_data_r;
    assign ack_rx_o    = ack_rx_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign busy_o      = busy_r;
endmodule

// File: tb/tb_i2c_burst_datapath.sv
// Directed scoreboard bench for i2c_burst_datapath (DATA_W=8, MSB first); a bus slave model
// answers frames. Stretch expectations follow I2C_DP_CLK_STRETCH_EN.
module tb_i2c_burst_datapath;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] presc = 8'd4;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ack = 1'b0;
    logic       cmd_ready, sda_i, scl_i, sda_o, scl_o, ack_rx, done, err, busy;
    logic [7:0] rd_data;
    logic       slv_drv = 1'b1;
    logic       scl_force = 1'b1;

    int n_checks = 0;
    int n_err = 0;
    int half = 5;
    logic [7:0] m_rd = 8'h00;
    logic       m_ack = 1'b1;

    typedef struct {
        string      tag;
        int         cycles;
        logic [7:0] rd;
        logic       ack_rx;
        int         fall_hi;
        int         rise_hi;
        int         rise_lo;
        bit         chk_bits;
        logic [7:0] bits;
        logic       ack_slot;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign sda_i = sda_o & slv_drv;
    assign scl_i = scl_o & scl_force;

    i2c_burst_datapath #(.DATA_W(8), .PRESC_W(8), .MSB_FIRST(1)) dut (
        .i2c_core_clock_i(clk), .reset_bit_n_i(rst_n), .prescaler_i(presc),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .cmd_ack_i(cmd_ack),
        .cmd_ready_o(cmd_ready), .sda_i(sda_i), .scl_i(scl_i), .sda_o(sda_o), .scl_o(scl_o),
        .rd_data_o(rd_data), .ack_rx_o(ack_rx), .done_o(done), .err_o(err), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int cycles, input int fall_hi,
                                input int rise_hi, input int rise_lo, input bit chk_bits,
                                input logic [7:0] bits, input logic ack_slot);
        exp_t e;
        e.tag = tag; e.cycles = cycles; e.rd = m_rd; e.ack_rx = m_ack;
        e.fall_hi = fall_hi; e.rise_hi = rise_hi; e.rise_lo = rise_lo;
        e.chk_bits = chk_bits; e.bits = bits; e.ack_slot = ack_slot;
        return e;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_scl"}, scl_o, 1);
        chk({tag, "_sda"}, sda_o, 1);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"}, rd_data, 0);
        chk({tag, "_ackrx"}, ack_rx, 1);
    endtask

    // Issue one command, play the slave, then pop the scoreboard entry when done_o appears.
    task automatic run_cmd(input exp_t e, input logic [2:0] op, input logic [7:0] data,
                           input logic ackbit, input logic [7:0] sbyte, input logic sack,
                           input bit stretch, input int rst_rise);
        int cyc = 0, rise = 0, left = 0, rst_wait = 0;
        int fall_hi = 0, rise_hi = 0, rise_lo = 0;
        logic prev_scl, prev_sda, ack_slot = 1'bx;
        logic [7:0] bits = 8'h00;
        bit frame = (op == 3'd1) || (op == 3'd2);
        bit rd = (op == 3'd2);
        exp_t g;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_ack = ackbit;
        prev_scl = scl_o; prev_sda = sda_o;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = ~data; cmd_ack = ~ackbit;
        while (1) begin
            if (sda_o !== prev_sda) begin
                if (scl_o && sda_o) rise_hi++;
                else if (scl_o)     fall_hi++;
                else if (sda_o)     rise_lo++;
            end
            if (scl_o && !prev_scl) begin
                rise++;
                if (rise <= 8) bits[8-rise] = sda_o;
                else if (rise == 9) ack_slot = sda_o;
                if (frame && rise <= 8) slv_drv = rd ? sbyte[8-rise] : 1'b1;
                else if (frame && rise == 9) slv_drv = rd ? 1'b1 : sack;
                else slv_drv = 1'b1;
                if (stretch && rise == 3) begin
                    scl_force = 1'b0;
                    left = 20;
                end
            end
            if (!scl_o && prev_scl) begin
                slv_drv = 1'b1;
                if (rise == rst_rise) rst_wait = 3;
            end
            prev_scl = scl_o; prev_sda = sda_o;
            if (rst_wait > 0) begin
                rst_wait--;
                if (rst_wait == 0) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset_vals({e.tag, "_midrst"});
                    g = exp_q.pop_front();
                    slv_drv = 1'b1; scl_force = 1'b1;
                    m_rd = 8'h00; m_ack = 1'b1;
                    @(negedge clk) rst_n = 1'b1;
                    return;
                end
            end
            if (done) break;
            if (cyc >= 3000) begin
                chk({e.tag, "_timeout"}, done, 1);
                g = exp_q.pop_front();
                return;
            end
            @(posedge clk);
            cyc++;
            if (left > 0) left--;
            @(negedge clk);
            if (left == 0) scl_force = 1'b1;
        end
        g = exp_q.pop_front();
        chk({g.tag, "_cycles"}, cyc, g.cycles);
        chk({g.tag, "_rd"}, rd_data, g.rd);
        chk({g.tag, "_ackrx"}, ack_rx, g.ack_rx);
        chk({g.tag, "_fall_hi"}, fall_hi, g.fall_hi);
        chk({g.tag, "_rise_hi"}, rise_hi, g.rise_hi);
        if (g.rise_lo >= 0) chk({g.tag, "_rise_lo"}, rise_lo, g.rise_lo);
        if (g.chk_bits) begin
            chk({g.tag, "_bits"}, bits, g.bits);
            chk({g.tag, "_ackslot"}, ack_slot, g.ack_slot);
        end
        @(negedge clk);
        chk({g.tag, "_done_once"}, done, 0);
    endtask

    // Illegal or out-of-context command: expect a single err_o pulse and a quiet bus.
    task automatic err_cmd(input string tag, input logic [2:0] op);
        logic s_scl, s_sda;
        int pulses = 0;
        @(negedge clk);
        s_scl = scl_o; s_sda = sda_o;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = 8'h55;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_err"}, err, 1);
        chk({tag, "_ready"}, cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (err || done || scl_o !== s_scl || sda_o !== s_sda) pulses++;
        end
        chk({tag, "_quiet"}, pulses, 0);
        chk({tag, "_ready_hold"}, cmd_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        run_cmd(mk("start", half, 1, 0, 0, 0, 8'h00, 1'b1), 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        chk("start_busy", busy, 1);
        chk("start_lines", {scl_o, sda_o}, 2'b00);

        m_ack = 1'b0;
        run_cmd(mk("wr_a5", 18 * half, 0, 0, -1, 1, 8'hA5, 1'b1), 3'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 0, -1);
        m_rd = 8'h3C;
        run_cmd(mk("rd_3c", 18 * half, 0, 0, -1, 1, 8'hFF, 1'b1), 3'd2, 8'h00, 1'b1, 8'h3C, 1'b1, 0, -1);
        m_rd = 8'hC3;
        run_cmd(mk("rd_c3", 18 * half, 0, 0, -1, 1, 8'hFF, 1'b0), 3'd2, 8'h00, 1'b0, 8'hC3, 1'b1, 0, -1);
        run_cmd(mk("rstart", 3 * half, 1, 0, 1, 0, 8'h00, 1'b1), 3'd4, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        m_ack = 1'b1;
        run_cmd(mk("wr_5a", 18 * half, 0, 0, -1, 1, 8'h5A, 1'b1), 3'd1, 8'h5A, 1'b0, 8'h00, 1'b1, 0, -1);
        run_cmd(mk("stop", 3 * half, 0, 1, 0, 0, 8'h00, 1'b1), 3'd3, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        chk("stop_busy", busy, 0);
        chk("stop_lines", {scl_o, sda_o}, 2'b11);
        chk("stop_ready", cmd_ready, 1);

        err_cmd("err_wr_idle", 3'd1);
        run_cmd(mk("start2", half, 1, 0, 0, 0, 8'h00, 1'b1), 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        err_cmd("err_op6_hold", 3'd6);
        run_cmd(mk("start_in_hold", 3 * half, 1, 0, 1, 0, 8'h00, 1'b1), 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);

        presc = 8'd0; half = 3;
        m_ack = 1'b0;
        run_cmd(mk("wr_p0", 18 * half, 0, 0, -1, 1, 8'h0F, 1'b1), 3'd1, 8'h0F, 1'b0, 8'h00, 1'b0, 0, -1);
        presc = 8'd4; half = 5;

        m_ack = 1'b1;
`ifdef I2C_DP_CLK_STRETCH_EN
        run_cmd(mk("wr_stretch", 18 * half + 20, 0, 0, -1, 1, 8'h96, 1'b1), 3'd1, 8'h96, 1'b0, 8'h00, 1'b1, 1, -1);
`else
        run_cmd(mk("wr_stretch", 18 * half, 0, 0, -1, 1, 8'h96, 1'b1), 3'd1, 8'h96, 1'b0, 8'h00, 1'b1, 1, -1);
`endif

        run_cmd(mk("wr_rst", 18 * half, 0, 0, -1, 0, 8'h00, 1'b1), 3'd1, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 3);
        @(negedge clk);
        chk_reset_vals("after_midrst");
        run_cmd(mk("start3", half, 1, 0, 0, 0, 8'h00, 1'b1), 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        chk("start3_busy", busy, 1);
        run_cmd(mk("stop3", 3 * half, 0, 1, 0, 0, 8'h00, 1'b1), 3'd3, 8'h00, 1'b0, 8'h00, 1'b1, 0, -1);
        chk("stop3_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
